clause_coefficient_packer: RTL
==============================

// Module: clause_coefficient_packer
// PURPOSE
//  Serial-to-parallel writer for one clause. Accepts literals one per handshake as (type, index, coefficient).
//  Assembles them into the packed integer/boolean coefficient words consumed by VariablesDetector and the clause datapath.
//  Presents the finished clause with a valid/ready handshake.
//  Sits between the clause-memory reader and VariablesDetector.
// PARAMETERS
//  MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX  1  log2 of integer slots per clause (NI = 2**this)
//  MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX  1  log2 of boolean slots per clause (NB = 2**this)
//  MAXIMUM_BIT_WIDTH_OF_INTEGER_COEFFICIENT     4  integer coefficient width (CI)
//  MAXIMUM_BIT_WIDTH_OF_BOOLEAN_COEFFICIENT     2  boolean coefficient width (CB, always 2)
//  Derived: IW = max(both index widths); LW = clog2(NI+NB+1)
// PORTS
//  clk                       in   1      rising-edge clock
//  reset                     in   1      synchronous, active-high
//  in_literal_valid          in   1      literal on inputs is valid
//  out_literal_ready         out  1      packer accepts a literal this cycle
//  in_literal_is_boolean     in   1      1 = boolean slot, 0 = integer slot
//  in_literal_index          in   IW     slot index
//  in_literal_coefficient    in   CI     coefficient; boolean uses bits [CB-1:0]
//  in_literal_last           in   1      final literal of clause
//  out_clause_valid          out  1      packed clause available
//  in_clause_ready           in   1      consumer takes clause
//  out_integer_coefficients  out  NI*CI  slot k at [k*CI +: CI]
//  out_boolean_coefficients  out  NB*CB  slot k at [k*CB +: CB]
//  out_literal_count         out  LW     literals accepted into current clause
//  out_error                 out  1      sticky per clause: dropped or duplicate literal
// BEHAVIOUR
//  Reset (sync, any state): both coefficient words=0, count=0, error=0, clause_valid=0, state=COLLECT.
//  FSM with two states:
//   COLLECT: out_literal_ready=1, out_clause_valid=0. Accept = valid&ready.
//     On accept, the selected slot takes the coefficient at the next edge.
//     Other slots are held. Count increments, saturating at NI+NB.
//     Accept with last=1 -> HOLD. Clause becomes visible the cycle after the last accept (latency 1).
//   HOLD: out_literal_ready=0, out_clause_valid=1. Words, count and error are stable.
//     On in_clause_ready=1: clear words, count and error -> COLLECT. out_clause_valid drops next cycle.
//     One clause in flight. No new literal is accepted in the same cycle as clause handoff.
//  Boundaries:
//   - Boolean literal with index >= NB, or with nonzero coefficient bits above CB-1:
//     not written, count unchanged, error=1. last is still honoured.
//   - Integer index bits above MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX nonzero: same drop rule.
//   - Second write to an already-written slot in the same clause: overwrite (latest wins), error=1, count still increments.
//     Track this with per-slot written flags, cleared at handoff.
//   - Zero coefficient is a legal write. It marks the slot written but leaves the slot zero (absent for VariablesDetector).
//   - in_literal_valid while in HOLD: ignored, no side effects.
//   - Reset asserted during COLLECT or HOLD: partial or complete clause is discarded.
//  No combinational path from in_* to out_* except none; all outputs are registered.
// TESTING
//  1. Defaults. Send int0=4'b0001, int1=4'b0011, bool0=2'b11, bool1=2'b01 with last
//     -> next cycle clause_valid=1, int=8'b0011_0001, bool=4'b01_11, count=3'd4, error=0.
//  2. Hold clause_ready=0 for 5 cycles while literal_valid=1
//     -> literal_ready=0, outputs unchanged. Pulse ready -> words=0, COLLECT next cycle.
//  3. int1=4'h5 then int1=4'hA with last -> int=8'hA0, count=2, error=1.
//  4. Boolean literal with coefficient 4'b0110, then int0=4'h1 with last
//     -> bool=4'b0000, int=8'h01, count=1, error=1.
//  5. Single literal bool0=2'b00 with last -> clause_valid=1, both words zero, count=1, error=0.
//  6. Two literals accepted, then reset high 1 cycle
//     -> all outputs zero, literal_ready=1. A fresh clause then packs correctly.

Source files
------------

// File: rtl/clause_coefficient_packer.sv
// Serial-to-parallel clause writer: literals arrive one per handshake and are
// packed into integer/boolean coefficient words, then handed off as one clause.

module coefficient_slot #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         write,
    input  logic [W-1:0] din,
    output logic [W-1:0] value,
    output logic         written
);
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            value   <= '0;
            written <= 1'b0;
        end else if (write) begin
            value   <= din;
            written <= 1'b1;
        end
    end
endmodule

module clause_coefficient_packer #(
    parameter int MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX = 1,
    parameter int MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX = 1,
    parameter int MAXIMUM_BIT_WIDTH_OF_INTEGER_COEFFICIENT    = 4,
    parameter int MAXIMUM_BIT_WIDTH_OF_BOOLEAN_COEFFICIENT    = 2,
    localparam int IIW = MAXIMUM_BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX,
    localparam int BIW = MAXIMUM_BIT_WIDTH_OF_BOOLEAN_VARIABLE_INDEX,
    localparam int CI  = MAXIMUM_BIT_WIDTH_OF_INTEGER_COEFFICIENT,
    localparam int CB  = MAXIMUM_BIT_WIDTH_OF_BOOLEAN_COEFFICIENT,
    localparam int NI  = 1 << IIW,
    localparam int NB  = 1 << BIW,
    localparam int IW  = (IIW > BIW) ? IIW : BIW,
    localparam int LW  = $clog2(NI + NB + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_literal_valid,
    output logic              out_literal_ready,
    input  logic              in_literal_is_boolean,
    input  logic [IW-1:0]     in_literal_index,
    input  logic [CI-1:0]     in_literal_coefficient,
    input  logic              in_literal_last,
    output logic              out_clause_valid,
    input  logic              in_clause_ready,
    output logic [NI*CI-1:0]  out_integer_coefficients,
    output logic [NB*CB-1:0]  out_boolean_coefficients,
    output logic [LW-1:0]     out_literal_count,
    output logic              out_error
);
    typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_t;

    state_t state, state_next;

    logic [NI-1:0][CI-1:0] int_value;
    logic [NB-1:0][CB-1:0] bool_value;
    logic [NI-1:0]         int_we, int_written;
    logic [NB-1:0]         bool_we, bool_written;
    logic                  accept, handoff, drop, dup;
    logic                  int_drop, bool_drop;
    logic [LW-1:0]         count;
    logic                  error;

    assign accept  = in_literal_valid && (state == COLLECT);
    assign handoff = (state == HOLD) && in_clause_ready;

    // Out-of-range index or oversized boolean coefficient drops the literal.
    assign int_drop  = (in_literal_index >> IIW) != '0;
    assign bool_drop = ((in_literal_index >> BIW) != '0) ||
                       ((in_literal_coefficient >> CB) != '0);
    assign drop      = in_literal_is_boolean ? bool_drop : int_drop;

    genvar k;
    generate
        for (k = 0; k < NI; k++) begin : g_int
            assign int_we[k] = accept && !in_literal_is_boolean && !drop &&
                               (in_literal_index[IIW-1:0] == IIW'(k));
            coefficient_slot #(.W(CI)) u_slot (
                .clk     (clk),
                .reset   (reset),
                .clear   (handoff),
                .write   (int_we[k]),
                .din     (in_literal_coefficient),
                .value   (int_value[k]),
                .written (int_written[k])
            );
        end
        for (k = 0; k < NB; k++) begin : g_bool
            assign bool_we[k] = accept && in_literal_is_boolean && !drop &&
                                (in_literal_index[BIW-1:0] == BIW'(k));
            coefficient_slot #(.W(CB)) u_slot (
                .clk     (clk),
                .reset   (reset),
                .clear   (handoff),
                .write   (bool_we[k]),
                .din     (in_literal_coefficient[CB-1:0]),
                .value   (bool_value[k]),
                .written (bool_written[k])
            );
        end
    endgenerate

    assign dup = (|(int_we & int_written)) || (|(bool_we & bool_written));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= COLLECT;
            count <= '0;
            error <= 1'b0;
        end else begin
            state <= state_next;
            if (handoff) begin
                count <= '0;
                error <= 1'b0;
            end else if (accept) begin
                if (drop) begin
                    error <= 1'b1;
                end else begin
                    if (count != LW'(NI + NB))
                        count <= count + LW'(1);
                    if (dup)
                        error <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            COLLECT: if (accept && in_literal_last) state_next = HOLD;
            HOLD:    if (in_clause_ready)           state_next = COLLECT;
            default: state_next = COLLECT;
        endcase
    end

    // Handshake outputs decode straight from the state flop.
    assign out_literal_ready        = (state == COLLECT);
    assign out_clause_valid         = (state == HOLD);
    assign out_integer_coefficients = int_value;
    assign out_boolean_coefficients = bool_value;
    assign out_literal_count        = count;
    assign out_error                = error;
endmodule
